// File: rtl/dma_controller_if.sv
// rtl/dma_controller_if.sv - CSR bus and read/write master handshake bundle for dma_controller
interface dma_controller_if;
  logic [2:0]  iCS_address;
  logic        iCS_write;
  logic [31:0] iCS_writedata;
  logic        iCS_read;
  logic [31:0] oCS_readdata;
  logic        oRM_start;
  logic [31:0] oRM_address;
  logic        oWM_start;
  logic [31:0] oWM_address;
  logic [31:0] oLength;
  logic        iRM_done;
  logic        iWM_done;
  logic        oIRQ;

  modport slave (
    input  iCS_address, iCS_write, iCS_writedata, iCS_read, iRM_done, iWM_done,
    output oCS_readdata, oRM_start, oRM_address, oWM_start, oWM_address, oLength, oIRQ
  );

  modport master (
    output iCS_address, iCS_write, iCS_writedata, iCS_read, iRM_done, iWM_done,
    input  oCS_readdata, oRM_start, oRM_address, oWM_start, oWM_address, oLength, oIRQ
  );
endinterface

// File: rtl/dma_controller.sv
// rtl/dma_controller.sv - CSR-programmed DMA sequencer launching a read and a write master
// Checks the length, pulses both masters, then waits for both completions, an abort or a timeout.
module dma_controller #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd65535
) (
  input  logic         iClk,
  input  logic         iReset,
  dma_controller_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CHECK, LAUNCH, RUN} state_t;

  state_t      state;
  logic [31:0] src;
  logic [31:0] dst;
  logic [31:0] len;
  logic [31:0] cycles;
  logic        irq_en;
  logic        st_done;
  logic        st_err_len;
  logic        st_timeout;
  logic        st_aborted;
  logic        rm_seen;
  logic        wm_seen;
  logic        rm_start;
  logic        wm_start;
  logic        irq;
  logic [31:0] readdata;

  logic        busy;
  logic        wr_ctrl;
  logic        wr_status;
  logic        go;
  logic        abort;
  logic        rm_hit;
  logic        wm_hit;
  logic        completing;
  logic [31:0] cycles_inc;
  logic [31:0] rd_mux;

  always_comb begin
    busy       = (state != IDLE);
    wr_ctrl    = bus.iCS_write && (bus.iCS_address == 3'd3);
    wr_status  = bus.iCS_write && (bus.iCS_address == 3'd4);
    go         = wr_ctrl && bus.iCS_writedata[0];
    abort      = wr_ctrl && bus.iCS_writedata[2];
    rm_hit     = rm_seen | bus.iRM_done;
    wm_hit     = wm_seen | bus.iWM_done;
    // Second done arriving this cycle: completion is already decided, so abort/timeout lose.
    completing = rm_hit & wm_hit;
    cycles_inc = (cycles == 32'hFFFF_FFFF) ? cycles : cycles + 32'd1;
  end

  always_comb begin
    rd_mux = 32'd0;
    case (bus.iCS_address)
      3'd0:    rd_mux = src;
      3'd1:    rd_mux = dst;
      3'd2:    rd_mux = len;
      3'd3:    rd_mux = {29'd0, 1'b0, irq_en, 1'b0};
      3'd4:    rd_mux = {27'd0, st_aborted, st_timeout, st_err_len, st_done, busy};
      3'd5:    rd_mux = cycles;
      default: rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state      <= IDLE;
      src        <= 32'd0;
      dst        <= 32'd0;
      len        <= 32'd0;
      cycles     <= 32'd0;
      irq_en     <= 1'b0;
      st_done    <= 1'b0;
      st_err_len <= 1'b0;
      st_timeout <= 1'b0;
      st_aborted <= 1'b0;
      rm_seen    <= 1'b0;
      wm_seen    <= 1'b0;
      rm_start   <= 1'b0;
      wm_start   <= 1'b0;
      irq        <= 1'b0;
      readdata   <= 32'd0;
    end else begin
      rm_start <= 1'b0;
      wm_start <= 1'b0;
      irq      <= irq_en & (st_done | st_err_len | st_timeout | st_aborted);

      if (bus.iCS_read) readdata <= rd_mux;

      if (bus.iCS_write && !busy) begin
        case (bus.iCS_address)
          3'd0:    src <= bus.iCS_writedata;
          3'd1:    dst <= bus.iCS_writedata;
          3'd2:    len <= bus.iCS_writedata;
          default: ;
        endcase
      end

      if (wr_ctrl) irq_en <= bus.iCS_writedata[1];

      // W1C first; hardware sets in the FSM below land later and therefore win.
      if (wr_status) begin
        if (bus.iCS_writedata[1]) st_done    <= 1'b0;
        if (bus.iCS_writedata[2]) st_err_len <= 1'b0;
        if (bus.iCS_writedata[3]) st_timeout <= 1'b0;
        if (bus.iCS_writedata[4]) st_aborted <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (go) state <= CHECK;
        end
        CHECK: begin
          if (len == 32'd0 || len[1:0] != 2'b00) begin
            st_err_len <= 1'b1;
            state      <= IDLE;
          end else begin
            st_done    <= 1'b0;
            st_timeout <= 1'b0;
            st_aborted <= 1'b0;
            cycles     <= 32'd0;
            rm_start   <= 1'b1;
            wm_start   <= 1'b1;
            state      <= LAUNCH;
          end
        end
        LAUNCH: begin
          state <= RUN;
        end
        RUN: begin
          if (rm_seen && wm_seen) begin
            st_done <= 1'b1;
            rm_seen <= 1'b0;
            wm_seen <= 1'b0;
            state   <= IDLE;
          end else if (abort && !completing) begin
            st_aborted <= 1'b1;
            rm_seen    <= 1'b0;
            wm_seen    <= 1'b0;
            state      <= IDLE;
          end else if (cycles >= TIMEOUT_CYCLES && !completing) begin
            st_timeout <= 1'b1;
            rm_seen    <= 1'b0;
            wm_seen    <= 1'b0;
            state      <= IDLE;
          end else begin
            rm_seen <= rm_hit;
            wm_seen <= wm_hit;
            cycles  <= cycles_inc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.oCS_readdata = readdata;
  assign bus.oRM_start    = rm_start;
  assign bus.oWM_start    = wm_start;
  assign bus.oRM_address  = src;
  assign bus.oWM_address  = dst;
  assign bus.oLength      = len;
  assign bus.oIRQ         = irq;

endmodule
